rob_recovery_ctrl: RTL
======================

# rob_recovery_ctrl

Sequences processor recovery after the ROB raises a mispredict nuke at commit. Over a fixed multi-cycle sequence it:
- broadcasts a flush to ROB, RS and LSQ;
- walks the architectural map table into the speculative map table, `WAYS` registers per cycle;
- pulses a free-list rebuild;
- redirects fetch to the corrected target.

In normal operation it also gates dispatch width against ROB occupancy. It sits between the ROB commit stage, the map tables, the free list and the fetch unit.

## Interface
Parameters:
- WAYS, default `WAYS (2): superscalar width; REGS must be a multiple of WAYS.
- REGS, default `REGS (32): architectural registers.
- PRF, default `PRF (64): physical registers.
- ROB, default `ROB (32): ROB entries.
- XLEN, default `XLEN (32): address width.

Ports:
- clock  in  1  sole clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- commit_nuke  in  1  ROB committed a mispredicted branch this cycle.
- nuke_target  in  XLEN  corrected PC; valid with commit_nuke.
- rob_free  in  $clog2(ROB)+1  ROB free-entry count (next_num_free).
- amt_rd_idx  out  WAYS x $clog2(REGS)  arch map table read indices.
- amt_rd_data  in  WAYS x $clog2(PRF)  arch map table data; combinational read, same cycle.
- mt_wr_en  out  WAYS  speculative map table write enables.
- mt_wr_idx  out  WAYS x $clog2(REGS)  map table write indices.
- mt_wr_data  out  WAYS x $clog2(PRF)  map table write data.
- flush  out  1  clear ROB/RS/LSQ speculative state.
- fl_rebuild  out  1  one-cycle pulse; free list recomputes from the arch map.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  XLEN  redirect address.
- dispatch_slots  out  $clog2(WAYS)+1  ways dispatch may fill this cycle.
- busy  out  1  recovery in progress (state != IDLE).
- recover_count  out  16  number of recoveries started; saturates at 16'hFFFF.

## Operation
State machine, 2-bit state, four states:
- IDLE
  - On commit_nuke: latch nuke_target, clear restore_idx, increment recover_count (saturating), go to FLUSH.
  - Otherwise stay in IDLE.
- FLUSH (1 cycle)
  - flush=1, fl_rebuild=0.
  - Go to RESTORE.
- RESTORE (REGS/WAYS cycles)
  - For each w: amt_rd_idx[w] = mt_wr_idx[w] = restore_idx+w, mt_wr_data[w] = amt_rd_data[w], mt_wr_en=all ones.
  - restore_idx += WAYS each cycle.
  - When restore_idx == REGS-WAYS: assert fl_rebuild this same cycle, then go to REDIRECT.
- REDIRECT (1 cycle)
  - redirect_valid=1, redirect_pc=latched target.
  - Go to IDLE.

Dispatch gating (combinational):
- dispatch_slots = 0 if busy or commit_nuke.
- Otherwise dispatch_slots = min(rob_free, WAYS).

Other rules:
- commit_nuke outside IDLE is ignored: the ROB is already flushed, so it cannot legally occur. The verification bench flags it as an assertion, but the RTL must not change state.
- restore_idx is $clog2(REGS) bits and never wraps mid-walk.
- Outputs not named for a state are 0 in that state.

## Timing
Reset:
- State IDLE, restore_idx=0, latched target=0, recover_count=0.
- All outputs 0, including dispatch_slots while reset is held.
- Reset asserted mid-recovery aborts immediately. After release: IDLE, no redirect, no partial writes issued.

Latency, with commit_nuke at cycle N:
- flush at N+1.
- RESTORE writes during N+2 .. N+1+REGS/WAYS.
- fl_rebuild on the last RESTORE cycle.
- redirect_valid at N+2+REGS/WAYS.
- IDLE at N+3+REGS/WAYS.
- Defaults (REGS=32, WAYS=2): redirect at N+18, dispatch re-enabled at N+19.

Other timing rules:
- busy is registered. dispatch_slots is combinational from state, commit_nuke and rob_free (zero-cycle path).
- A new commit_nuke is accepted in the same cycle the FSM returns to IDLE (N+3+REGS/WAYS).
- rob_free == ROB: dispatch_slots = WAYS.
- rob_free == 0: dispatch_slots = 0.

## Structure
- Shared package rob_pkg holds:
  - recov_state_e enum {IDLE, FLUSH, RESTORE, REDIRECT};
  - the rob_entry typedef;
  - constants RESTORE_CYCLES = REGS/WAYS and ROB_IDX_W = $clog2(ROB).
- Single module; no sub-module. The restore walker is a counter plus a mux, kept inline.
- Elaboration-time assertion: REGS % WAYS == 0.

## Test plan
- Reset held low mid-RESTORE at restore_idx=8, then released -> state IDLE, mt_wr_en=0, redirect_valid never asserts, busy=0.
- commit_nuke at cycle 10 with nuke_target=32'h0000_1040 -> flush at 11; mt writes idx {0,1}..{30,31} at cycles 12–27 carrying AMT data; fl_rebuild at 27; redirect_valid with pc 32'h0000_1040 at 28; busy=0 at 29.
- rob_free sweep 0,1,2,32 in IDLE -> dispatch_slots 0,1,2,2; with commit_nuke=1, rob_free=32 -> dispatch_slots 0.
- Second commit_nuke in the cycle busy falls (N+19) -> accepted, flush next cycle, recover_count=2.
- Spurious commit_nuke during RESTORE -> ignored, walk completes unchanged, recover_count not incremented.
- Force recover_count to 16'hFFFF, trigger one recovery -> count stays 16'hFFFF.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared recovery types and constants for the ROB recovery sequencer.
// Defaults here size the control block and the ROB entry layout.
package rob_pkg;

    localparam int DEF_WAYS = 2;
    localparam int DEF_REGS = 32;
    localparam int DEF_PRF  = 64;
    localparam int DEF_ROB  = 32;
    localparam int DEF_XLEN = 32;

    localparam int RESTORE_CYCLES = DEF_REGS / DEF_WAYS;
    localparam int ROB_IDX_W      = $clog2(DEF_ROB);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        RESTORE  = 2'd2,
        REDIRECT = 2'd3
    } recov_state_e;

    typedef struct packed {
        logic                        valid;
        logic                        done;
        logic                        mispredict;
        logic [$clog2(DEF_REGS)-1:0] dest_areg;
        logic [$clog2(DEF_PRF)-1:0]  dest_preg;
        logic [$clog2(DEF_PRF)-1:0]  old_preg;
        logic [DEF_XLEN-1:0]         target;
    } rob_entry;

endpackage

// File: rtl/rob_recovery_ctrl.sv
// Mispredict recovery sequencer: flush, arch->spec map walk, free-list rebuild, fetch redirect.
// Latency nuke->redirect is 2+REGS/WAYS cycles; dispatch is throttled combinationally by ROB space.
module rob_recovery_ctrl
    import rob_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int REGS = DEF_REGS,
    parameter int PRF  = DEF_PRF,
    parameter int ROB  = DEF_ROB,
    parameter int XLEN = DEF_XLEN
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              commit_nuke_i,
    input  logic [XLEN-1:0]                   nuke_target_i,
    input  logic [$clog2(ROB):0]              rob_free_i,
    output logic [WAYS*$clog2(REGS)-1:0]      amt_rd_idx_o,
    input  logic [WAYS*$clog2(PRF)-1:0]       amt_rd_data_i,
    output logic [WAYS-1:0]                   mt_wr_en_o,
    output logic [WAYS*$clog2(REGS)-1:0]      mt_wr_idx_o,
    output logic [WAYS*$clog2(PRF)-1:0]       mt_wr_data_o,
    output logic                              flush_o,
    output logic                              fl_rebuild_o,
    output logic                              redirect_valid_o,
    output logic [XLEN-1:0]                   redirect_pc_o,
    output logic [$clog2(WAYS):0]             dispatch_slots_o,
    output logic                              busy_o,
    output logic [15:0]                       recover_count_o
);

    localparam int IW  = $clog2(REGS);
    localparam int PW  = $clog2(PRF);
    localparam int RFW = $clog2(ROB) + 1;
    localparam int SW  = $clog2(WAYS) + 1;

    localparam logic [IW-1:0]  LAST_IDX = IW'(REGS - WAYS);
    localparam logic [IW-1:0]  IDX_STEP = IW'(WAYS);
    localparam logic [RFW-1:0] WAYS_RF  = RFW'(WAYS);
    localparam logic [SW-1:0]  WAYS_SW  = SW'(WAYS);

    if (REGS % WAYS != 0) begin : g_bad_ways
        $error("rob_recovery_ctrl: REGS must be a multiple of WAYS");
    end

    recov_state_e    state_q;
    logic [IW-1:0]   restore_idx_q;
    logic [XLEN-1:0] target_q;
    logic [15:0]     count_q;
    logic [15:0]     count_d;
    logic            flush_q;
    logic            busy_q;
    logic            redirect_q;
    logic            restoring;

    assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    // Nukes outside IDLE are unreachable in a legal pipeline and are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            restore_idx_q <= '0;
            target_q      <= '0;
            count_q       <= '0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            redirect_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (commit_nuke_i) begin
                        state_q       <= FLUSH;
                        target_q      <= nuke_target_i;
                        restore_idx_q <= '0;
                        count_q       <= count_d;
                        flush_q       <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_q <= RESTORE;
                    flush_q <= 1'b0;
                end
                RESTORE: begin
                    if (restore_idx_q == LAST_IDX) begin
                        state_q    <= REDIRECT;
                        redirect_q <= 1'b1;
                    end else begin
                        restore_idx_q <= restore_idx_q + IDX_STEP;
                    end
                end
                REDIRECT: begin
                    state_q    <= IDLE;
                    redirect_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign restoring = (state_q == RESTORE);

    // Walker: AMT read is same-cycle, so its data goes straight to the spec map write port.
    always_comb begin
        amt_rd_idx_o = '0;
        mt_wr_idx_o  = '0;
        mt_wr_data_o = '0;
        if (restoring) begin
            for (int w = 0; w < WAYS; w++) begin
                amt_rd_idx_o[w*IW +: IW] = restore_idx_q + IW'(w);
                mt_wr_idx_o[w*IW +: IW]  = restore_idx_q + IW'(w);
                mt_wr_data_o[w*PW +: PW] = amt_rd_data_i[w*PW +: PW];
            end
        end
    end

    assign mt_wr_en_o   = {WAYS{restoring}};
    assign fl_rebuild_o = restoring && (restore_idx_q == LAST_IDX);

    always_comb begin
        dispatch_slots_o = '0;
        if (rst_ni && !busy_q && !commit_nuke_i) begin
            dispatch_slots_o = (rob_free_i > WAYS_RF) ? WAYS_SW : rob_free_i[SW-1:0];
        end
    end

    assign flush_o          = flush_q;
    assign busy_o           = busy_q;
    assign redirect_valid_o = redirect_q;
    assign redirect_pc_o    = redirect_q ? target_q : '0;
    assign recover_count_o  = count_q;

endmodule
